// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB4 requester.
//   - FSM state encodings (IDLE, SETUP, ACCESS)
//   - default address/data widths
//   - pprot attribute bit constants
package apb_pkg;

    localparam int unsigned defaultAddrWidth = 32;
    localparam int unsigned defaultDataWidth = 32;

    localparam int unsigned stateWidth = 2;
    localparam logic [stateWidth-1:0] IDLE   = 2'd0;
    localparam logic [stateWidth-1:0] SETUP  = 2'd1;
    localparam logic [stateWidth-1:0] ACCESS = 2'd2;

    // pprot[0]=privileged, pprot[1]=non-secure, pprot[2]=instruction
    localparam logic [2:0] pprotDefault     = 3'b000;
    localparam logic [2:0] pprotPrivileged  = 3'b001;
    localparam logic [2:0] pprotNonSecure   = 3'b010;
    localparam logic [2:0] pprotInstruction = 3'b100;

endpackage

// File: rtl/apb_master.sv
// apb_master: APB4 requester bridge. Takes a level-held local command and runs one
// SETUP/ACCESS transfer on the APB bus, returning read data, error status and a one-cycle
// completion pulse.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   pselxM..pstrbM              local command (level, held until preadyM)
//   preadyM, prdataM, pslverrM  completion pulse, read data, slave error to requester
//   psel..pstrb                 APB request outputs (all registered)
//   pready, prdata, pslverr     APB completion inputs (sampled only in ACCESS)
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned addrWidth = defaultAddrWidth,
    parameter int unsigned dataWidth = defaultDataWidth
) (
    input  logic                   clk,
    input  logic                   rst,
    // local requester side
    input  logic                   pselxM,
    input  logic                   pwriteM,
    input  logic [2:0]             pprotM,
    input  logic [addrWidth-1:0]   paddrM,
    input  logic [dataWidth-1:0]   pwdataM,
    input  logic [dataWidth/8-1:0] pstrbM,
    output logic                   preadyM,
    output logic [dataWidth-1:0]   prdataM,
    output logic                   pslverrM,
    // APB side
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [2:0]             pprot,
    output logic [addrWidth-1:0]   paddr,
    output logic [dataWidth-1:0]   pwdata,
    output logic [dataWidth/8-1:0] pstrb,
    input  logic                   pready,
    input  logic [dataWidth-1:0]   prdata,
    input  logic                   pslverr
);

    logic [stateWidth-1:0] state;
    logic [stateWidth-1:0] stateNext;

    logic startXfer;
    logic doneXfer;

    assign startXfer = (state == IDLE) && pselxM;
    assign doneXfer  = (state == ACCESS) && pready;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (pselxM) stateNext = SETUP;
            SETUP:   stateNext = ACCESS;
            ACCESS:  if (pready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // psel/penable are registered so they change only on clock edges (or async reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end else begin
            case (stateNext)
                SETUP: begin
                    psel    <= 1'b1;
                    penable <= 1'b0;
                end
                ACCESS: begin
                    psel    <= 1'b1;
                    penable <= 1'b1;
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

    // Command is captured only when a transfer starts, so it stays stable through ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwrite <= 1'b0;
            pprot  <= 3'b000;
            paddr  <= '0;
            pwdata <= '0;
            pstrb  <= '0;
        end else if (startXfer) begin
            pwrite <= pwriteM;
            pprot  <= pprotM;
            paddr  <= paddrM;
            pwdata <= pwdataM;
            // Reads must present all-zero strobes.
            pstrb  <= pwriteM ? pstrbM : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preadyM  <= 1'b0;
            prdataM  <= '0;
            pslverrM <= 1'b0;
        end else begin
            preadyM <= doneXfer;
            if (doneXfer) begin
                pslverrM <= pslverr;
                if (!pwrite) begin
                    prdataM <= prdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

    logic        clk;
    logic        rst;
    logic        pselxM;
    logic        pwriteM;
    logic [2:0]  pprotM;
    logic [31:0] paddrM;
    logic [31:0] pwdataM;
    logic [3:0]  pstrbM;
    logic        preadyM;
    logic [31:0] prdataM;
    logic        pslverrM;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [2:0]  pprot;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    apb_master dut (
        .clk      (clk),
        .rst      (rst),
        .pselxM   (pselxM),
        .pwriteM  (pwriteM),
        .pprotM   (pprotM),
        .paddrM   (paddrM),
        .pwdataM  (pwdataM),
        .pstrbM   (pstrbM),
        .preadyM  (preadyM),
        .prdataM  (prdataM),
        .pslverrM (pslverrM),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pprot    (pprot),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  prot;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;     // value on the prdata bus at completion
        logic [31:0] expRdata;  // expected prdataM after completion
        logic        expErr;
        logic [3:0]  expStrb;
    } vecT;

    int tests = 0;
    int fails = 0;
    vecT vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        pselxM  = 1'b0;
        pwriteM = 1'b0;
        pprotM  = 3'b000;
        paddrM  = 32'h0;
        pwdataM = 32'h0;
        pstrbM  = 4'h0;
        pready  = 1'b0;
        prdata  = 32'h0;
        pslverr = 1'b0;
    endtask

    // Runs one transfer, checking every cycle from SETUP to the cycle after completion.
    task automatic runVec(input int idx, input vecT v);
        string t;
        t = $sformatf("v%0d", idx);
        pselxM  = 1'b1;
        pwriteM = v.wr;
        pprotM  = v.prot;
        paddrM  = v.addr;
        pwdataM = v.wdata;
        pstrbM  = v.strb;
        // Bus completion inputs outside ACCESS must be ignored.
        pready  = 1'b1;
        pslverr = 1'b1;
        @(negedge clk);
        check({t, " setup psel"}, {31'b0, psel}, 32'd1);
        check({t, " setup penable"}, {31'b0, penable}, 32'd0);
        check({t, " setup paddr"}, paddr, v.addr);
        check({t, " setup pwrite"}, {31'b0, pwrite}, {31'b0, v.wr});
        check({t, " setup pprot"}, {29'b0, pprot}, {29'b0, v.prot});
        check({t, " setup pstrb"}, {28'b0, pstrb}, {28'b0, v.expStrb});
        // Command changes mid-transfer must not reach the bus.
        pselxM  = 1'b0;
        paddrM  = ~v.addr;
        pwdataM = ~v.wdata;
        pwriteM = ~v.wr;
        pstrbM  = ~v.strb;
        pready  = 1'b0;
        pslverr = 1'b0;
        for (int w = 0; w <= v.waits; w++) begin
            @(negedge clk);
            check($sformatf("%s access%0d penable", t, w), {31'b0, penable}, 32'd1);
            check($sformatf("%s access%0d psel", t, w), {31'b0, psel}, 32'd1);
            check($sformatf("%s access%0d preadyM", t, w), {31'b0, preadyM}, 32'd0);
            check($sformatf("%s access%0d paddr", t, w), paddr, v.addr);
            check($sformatf("%s access%0d pwdata", t, w), pwdata, v.wdata);
            pready  = (w == v.waits);
            pslverr = (w == v.waits) ? v.slverr : 1'b1;
            prdata  = (w == v.waits) ? v.rdata : 32'hFFFF_0000;
        end
        @(negedge clk);
        check({t, " done preadyM"}, {31'b0, preadyM}, 32'd1);
        check({t, " done psel"}, {31'b0, psel}, 32'd0);
        check({t, " done penable"}, {31'b0, penable}, 32'd0);
        check({t, " done prdataM"}, prdataM, v.expRdata);
        check({t, " done pslverrM"}, {31'b0, pslverrM}, {31'b0, v.expErr});
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h0BAD_0BAD;
        @(negedge clk);
        check({t, " post preadyM"}, {31'b0, preadyM}, 32'd0);
        check({t, " post psel"}, {31'b0, psel}, 32'd0);
        check({t, " post prdataM"}, prdataM, v.expRdata);
        check({t, " post pslverrM"}, {31'b0, pslverrM}, {31'b0, v.expErr});
        idleInputs();
    endtask

    initial begin
        //              wr    prot    addr          wdata         strb  w  err   rdata         expRdata      eErr  eStrb
        vecs[0] = '{1'b1, 3'b000, 32'h0000_0100, 32'h0000_002A, 4'hF, 0, 1'b0, 32'hBAD0_BAD0, 32'h0,        1'b0, 4'hF};
        vecs[1] = '{1'b1, 3'b001, 32'h0000_0104, 32'hDEAD_BEEF, 4'h3, 3, 1'b0, 32'hBAD0_BAD0, 32'h0,        1'b0, 4'h3};
        vecs[2] = '{1'b0, 3'b010, 32'h0000_0200, 32'h0000_1111, 4'hA, 0, 1'b0, 32'h0000_07FF, 32'h0000_07FF, 1'b0, 4'h0};
        vecs[3] = '{1'b0, 3'b000, 32'h0000_0300, 32'h0,         4'hF, 1, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 4'h0};
        vecs[4] = '{1'b1, 3'b100, 32'h0000_0400, 32'h0000_0055, 4'h0, 0, 1'b0, 32'hBAD0_BAD0, 32'h1234_5678, 1'b0, 4'h0};
        vecs[5] = '{1'b0, 3'b111, 32'hFFFF_FFFC, 32'h0,         4'h5, 2, 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 4'h0};

        idleInputs();
        rst = 1'b1;
        #1;
        check("reset psel", {31'b0, psel}, 32'd0);
        check("reset penable", {31'b0, penable}, 32'd0);
        check("reset preadyM", {31'b0, preadyM}, 32'd0);
        check("reset paddr", paddr, 32'd0);
        check("reset prdataM", prdataM, 32'd0);
        check("reset pslverrM", {31'b0, pslverrM}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle psel", {31'b0, psel}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            runVec(i, vecs[i]);
        end

        // Back-to-back: pselxM held high, next command presented in the completion cycle.
        pselxM  = 1'b1;
        pwriteM = 1'b1;
        paddrM  = 32'h0000_0A00;
        pwdataM = 32'h0000_00AA;
        pstrbM  = 4'hF;
        @(negedge clk);
        check("b2b A setup psel", {31'b0, psel}, 32'd1);
        check("b2b A setup paddr", paddr, 32'h0000_0A00);
        pready = 1'b1;
        @(negedge clk);
        check("b2b A access penable", {31'b0, penable}, 32'd1);
        paddrM  = 32'h0000_0B00;
        pwdataM = 32'h0000_00BB;
        @(negedge clk);
        check("b2b A done preadyM", {31'b0, preadyM}, 32'd1);
        check("b2b idle gap psel", {31'b0, psel}, 32'd0);
        @(negedge clk);
        check("b2b B setup psel", {31'b0, psel}, 32'd1);
        check("b2b B setup penable", {31'b0, penable}, 32'd0);
        check("b2b B setup paddr", paddr, 32'h0000_0B00);
        check("b2b B setup preadyM", {31'b0, preadyM}, 32'd0);
        pselxM = 1'b0;
        @(negedge clk);
        check("b2b B access pwdata", pwdata, 32'h0000_00BB);
        @(negedge clk);
        check("b2b B done preadyM", {31'b0, preadyM}, 32'd1);
        idleInputs();
        @(negedge clk);
        check("b2b B post psel", {31'b0, psel}, 32'd0);

        // Reset during ACCESS: outputs must drop without a clock edge.
        pselxM  = 1'b1;
        pwriteM = 1'b0;
        paddrM  = 32'h0000_0C00;
        @(negedge clk);
        pselxM = 1'b0;
        @(negedge clk);
        check("rstmid pre penable", {31'b0, penable}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid psel", {31'b0, psel}, 32'd0);
        check("rstmid penable", {31'b0, penable}, 32'd0);
        check("rstmid preadyM", {31'b0, preadyM}, 32'd0);
        check("rstmid prdataM", prdataM, 32'd0);
        pready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid after psel", {31'b0, psel}, 32'd0);
        check("rstmid after preadyM", {31'b0, preadyM}, 32'd0);
        idleInputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
